data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised, multi-cycle data memory for the pipelined core's MEM stage. It replaces the single-cycle word-only data memory with a byte-addressed, little-endian store that supports byte, halfword and word accesses. Loads are sign- or zero-extended, and misaligned accesses are detected. A request/ready handshake with a programmable number of wait states lets the pipeline stall on memory. Contents are cleared on reset; word 0 stays visible on a test port.

## Interface
- DATA_WIDTH, 32, word width in bits; multiple of 8, at least 16
- ADDRESS_WIDTH, 32, byte-address width
- DEPTH, 128, number of words
- WAIT_STATES, 2, extra cycles per access, 0..15
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low; clears FSM, outputs and all memory words
- req  in  1  request; sampled only in IDLE
- we  in  1  1 = store, 0 = load
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- unsignedLoad  in  1  1 = zero-extend sub-word loads, 0 = sign-extend
- addr  in  ADDRESS_WIDTH  byte address
- writeData  in  DATA_WIDTH  store data, low-aligned (byte in [7:0], half in [15:0])
- readData  out  DATA_WIDTH  registered load result
- ready  out  1  one-cycle completion pulse
- misaligned  out  1  one-cycle error pulse, coincident with ready
- testData  out  DATA_WIDTH  combinational view of word 0

## Operation
- Let B = DATA_WIDTH/8 and L = log2(B).
- Word index = addr[L +: log2(DEPTH)]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Lane offset k = addr[L-1:0]. Byte lane k is data bits [8k+7:8k].
- FSM states: IDLE, BUSY.
  - In IDLE, req=1 captures we, size, unsignedLoad, addr and writeData, loads cnt with WAIT_STATES, and moves to BUSY.
  - In BUSY, req is ignored and captured values are used, so inputs may change after acceptance.
  - In BUSY with cnt≠0: cnt decrements.
  - In BUSY with cnt=0: the access is performed, ready is set to 1 for one cycle, and the state returns to IDLE.
- Alignment rules:
  - A halfword requires k[0]=0.
  - A word requires k=0.
  - size=11 is always an error.
- Error access: follows the same latency, with no memory write and readData unchanged; misaligned=1 together with ready.
- Store byte: writes writeData[7:0] to lane k only.
- Store half: writes writeData[15:0] to lanes k and k+1.
- Store word: writes all lanes.
- Lanes outside the access are unchanged.
- Load: selects the same lanes and places them in the low bits. Upper bits are filled with the top bit of the selected field when unsignedLoad=0, else with 0. A word load is the unmodified word.
- readData holds its value until the next successful load completes; stores do not change it.
- testData always reflects word 0, including a store completed in the previous cycle.

## Timing
- Reset values: state IDLE, cnt 0, ready 0, misaligned 0, readData 0, all memory words 0.
- Reset asserted mid-access: the access is abandoned and no write occurs.
- Latency: request accepted at edge E0 → memory update and ready/misaligned/readData visible after edge E0+WAIT_STATES+1.
- ready is high for exactly one cycle per accepted request.
- Back-to-back requests: a request is accepted at the edge that ends the ready cycle (the FSM is in IDLE). With WAIT_STATES=0, this gives one completion every 2 cycles.
- A load following a store to the same word returns the stored data, because the write commits before the next request is accepted.

## Test plan
- Reset then full readback: deassert reset, issue word loads at 0..(DEPTH-1)*4 → every readData=0 and testData=0.
- Word store and load, WAIT_STATES=2: store 0xDEADBEEF at addr 0x10 (req at E0) → ready after E3, not before. Word load at 0x10 → readData=0xDEADBEEF with the same latency.
- Byte and half stores, sign/zero extension: store byte 0x80 at 0x21, then half 0xF00D at 0x22 → word 0x20 = 0xF00D8000. Then:
  - signed byte load at 0x21 → 0xFFFFFF80
  - unsigned byte load at 0x21 → 0x00000080
  - signed half load at 0x22 → 0xFFFFF00D
- Misalignment: set word 0x40 = 0x12345678. Then:
  - half store at 0x41 → misaligned=1 with ready, word unchanged.
  - word load at 0x42 → misaligned=1, readData holds the previous value.
  - size=11 → misaligned=1.
- Handshake and wrap-around:
  - Toggle req and addr during BUSY → ignored.
  - With WAIT_STATES=0, back-to-back requests → one ready every 2 cycles.
  - Store 0xA5A5A5A5 at byte addr DEPTH*4 → word 0 written, testData=0xA5A5A5A5.
- Reset mid-access: assert reset during BUSY of a store of 0x11111111 to 0x08 → ready=0 immediately. After release, word load at 0x08 → 0.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// Byte-addressed, little-endian data memory for the MEM stage: byte/half/word
// accesses, sign/zero-extended loads, misalignment detection and a wait-state handshake.
module data_mem_ctrl #(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH         = 128,
    parameter int WAIT_STATES   = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req,
    input  logic                     we,
    input  logic [1:0]               size,
    input  logic                     unsignedLoad,
    input  logic [ADDRESS_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0]    writeData,
    output logic [DATA_WIDTH-1:0]    readData,
    output logic                     ready,
    output logic                     misaligned,
    output logic [DATA_WIDTH-1:0]    testData
);
    localparam int BYTES   = DATA_WIDTH / 8;
    localparam int LANE_W  = $clog2(BYTES);
    localparam int INDEX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int USED_W  = LANE_W + INDEX_W;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t                state, state_next;
    logic [3:0]            cnt, cnt_next;
    logic                  accept, finish, error;

    logic                  we_q, unsigned_q;
    logic [1:0]            size_q;
    logic [USED_W-1:0]     addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [INDEX_W-1:0]    index;
    logic [LANE_W-1:0]     lane;
    logic [BYTES-1:0]      byte_en;
    logic [DATA_WIDTH-1:0] wdata_shift, field, load_value;

    // Address bits above the word index wrap the memory and are deliberately dropped.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[ADDRESS_WIDTH-1:USED_W];

    assign index    = addr_q[LANE_W +: INDEX_W];
    assign lane     = addr_q[LANE_W-1:0];
    assign testData = mem[0];

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: if (req) begin
                accept     = 1'b1;
                cnt_next   = 4'(WAIT_STATES);
                state_next = BUSY;
            end
            BUSY: if (cnt != 4'd0) begin
                cnt_next = cnt - 4'd1;
            end else begin
                finish     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        error       = 1'b1;
        byte_en     = '0;
        wdata_shift = wdata_q << (8 * lane);
        case (size_q)
            2'b00: begin error = 1'b0;            byte_en = BYTES'(1) << lane; end
            2'b01: begin error = lane[0];         byte_en = BYTES'(3) << lane; end
            2'b10: begin error = (lane != '0);    byte_en = '1;                end
            default: ;
        endcase
    end

    always_comb begin
        field = mem[index] >> (8 * lane);
        case (size_q)
            2'b00:   load_value = unsigned_q ? DATA_WIDTH'(field[7:0])
                                             : DATA_WIDTH'($signed(field[7:0]));
            2'b01:   load_value = unsigned_q ? DATA_WIDTH'(field[15:0])
                                             : DATA_WIDTH'($signed(field[15:0]));
            default: load_value = field;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready      <= 1'b0;
            misaligned <= 1'b0;
            readData   <= '0;
            we_q       <= 1'b0;
            unsigned_q <= 1'b0;
            size_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            ready      <= finish;
            misaligned <= finish & error;
            if (accept) begin
                we_q       <= we;
                unsigned_q <= unsignedLoad;
                size_q     <= size;
                addr_q     <= addr[USED_W-1:0];
                wdata_q    <= writeData;
            end
            if (finish && !error && !we_q)
                readData <= load_value;
        end
    end

    // NOTE: the array is cleared by reset, so it is built from flops rather than a RAM macro.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem <= '{default: '0};
        end else if (finish && we_q && !error) begin
            for (int b = 0; b < BYTES; b++)
                if (byte_en[b])
                    mem[index][8*b +: 8] <= wdata_shift[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: a byte-array reference model predicts each
// completion; a monitor compares whenever ready pulses. Unit 0 has 2 wait states, unit 1 none.
module tb_data_mem_ctrl;
    localparam int DEPTH = 128;
    localparam int W0    = 2;
    localparam int W1    = 0;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        logic [31:0] td;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req [2];
    logic        we [2];
    logic [1:0]  size [2];
    logic        uns [2];
    logic [31:0] addr [2];
    logic [31:0] wdata [2];
    logic [31:0] rdata0, rdata1, tdata0, tdata1;
    logic        ready0, ready1, mis0, mis1;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t q0[$];
    exp_t q1[$];
    logic [7:0]  mdl_mem [2][DEPTH*4];
    logic [31:0] mdl_rd [2];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(W0)) dut (
        .clk(clk), .reset(reset), .req(req[0]), .we(we[0]), .size(size[0]),
        .unsignedLoad(uns[0]), .addr(addr[0]), .writeData(wdata[0]),
        .readData(rdata0), .ready(ready0), .misaligned(mis0), .testData(tdata0));

    data_mem_ctrl #(.DATA_WIDTH(32), .ADDRESS_WIDTH(32), .DEPTH(DEPTH), .WAIT_STATES(W1)) dut_fast (
        .clk(clk), .reset(reset), .req(req[1]), .we(we[1]), .size(size[1]),
        .unsignedLoad(uns[1]), .addr(addr[1]), .writeData(wdata[1]),
        .readData(rdata1), .ready(ready1), .misaligned(mis1), .testData(tdata1));

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void clear_model();
        for (int u = 0; u < 2; u++) begin
            mdl_rd[u] = '0;
            for (int i = 0; i < DEPTH*4; i++) mdl_mem[u][i] = 8'h00;
        end
    endfunction

    // Byte-level memory: alignment is address mod access size, loads gather little-endian bytes.
    function automatic exp_t model(int u, logic w, logic [1:0] sz, logic un,
                                   logic [31:0] a, logic [31:0] wd);
        exp_t        e;
        int unsigned ba = a % (DEPTH*4);
        int          n = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
        logic [31:0] v = '0;
        e.mis = (sz == 2'b11) || (ba % n != 0);
        if (!e.mis) begin
            if (w) begin
                for (int i = 0; i < n; i++) mdl_mem[u][ba+i] = wd[8*i +: 8];
            end else begin
                for (int i = 0; i < n; i++) v[8*i +: 8] = mdl_mem[u][ba+i];
                if (!un && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
                mdl_rd[u] = v;
            end
        end
        e.rd  = mdl_rd[u];
        e.td  = {mdl_mem[u][3], mdl_mem[u][2], mdl_mem[u][1], mdl_mem[u][0]};
        e.cyc = 0;
        return e;
    endfunction

    // Called at a falling edge; returns at the falling edge inside the ready cycle.
    task automatic issue(int u, logic w, logic [1:0] sz, logic un, logic [31:0] a, logic [31:0] wd);
        exp_t e;
        int   waited = 0;
        logic rdy;
        req[u] = 1'b1; we[u] = w; size[u] = sz; uns[u] = un; addr[u] = a; wdata[u] = wd;
        e = model(u, w, sz, un, a, wd);
        e.cyc = cyc + ((u == 0) ? W0 : W1) + 2;
        if (u == 0) q0.push_back(e); else q1.push_back(e);
        @(posedge clk); #1;
        req[u] = 1'b0; we[u] = 1'($urandom); size[u] = 2'($urandom); uns[u] = 1'($urandom);
        addr[u] = $urandom; wdata[u] = $urandom;
        forever begin
            @(negedge clk);
            rdy = (u == 0) ? ready0 : ready1;
            if (rdy) begin
                req[u] = 1'b0;
                break;
            end
            if (++waited > 40) begin
                check($sformatf("u%0d_ready_timeout", u), 32'(rdy), 32'd1);
                break;
            end
            req[u] = 1'($urandom);
            addr[u] = $urandom;
        end
    endtask

    task automatic mon(int u, logic rdy, logic ms, logic [31:0] rd, logic [31:0] td);
        exp_t e;
        int   depth = (u == 0) ? q0.size() : q1.size();
        if (rdy) begin
            if (depth == 0) begin
                check($sformatf("u%0d_spurious_ready", u), 32'(rdy), 32'd0);
            end else begin
                if (u == 0) e = q0.pop_front(); else e = q1.pop_front();
                check($sformatf("u%0d_readData", u), rd, e.rd);
                check($sformatf("u%0d_misaligned", u), 32'(ms), 32'(e.mis));
                check($sformatf("u%0d_testData", u), td, e.td);
                check($sformatf("u%0d_latency_cycle", u), cyc, e.cyc);
            end
        end else if (ms) begin
            check($sformatf("u%0d_misaligned_without_ready", u), 32'(ms), 32'd0);
        end
    endtask

    always @(negedge clk) begin
        if (reset) begin
            mon(0, ready0, mis0, rdata0, tdata0);
            mon(1, ready1, mis1, rdata1, tdata1);
        end
    end

    function automatic logic [31:0] rand_addr();
        logic [31:0] a = $urandom;
        a[8:2] = 7'($urandom_range(15, 0));
        if ($urandom_range(3, 0) != 0) a[1:0] = 2'b00;
        return a;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int u = 0; u < 2; u++) begin
            req[u] = 1'b0; we[u] = 1'b0; size[u] = 2'b10; uns[u] = 1'b0;
            addr[u] = '0; wdata[u] = '0;
        end
        clear_model();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready0), 32'd0);
        check("reset_misaligned", 32'(mis0), 32'd0);
        check("reset_readData", rdata0, 32'd0);
        check("reset_testData", tdata0, 32'd0);
        check("reset_fast_ready", 32'(ready1), 32'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) issue(0, 1'b0, 2'b10, 1'b0, 32'(i*4), $urandom);

        issue(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h10, $urandom);
        check("word_load_deadbeef", rdata0, 32'hDEADBEEF);

        issue(0, 1'b1, 2'b00, 1'b0, 32'h21, 32'h1234_5680);
        issue(0, 1'b1, 2'b01, 1'b0, 32'h22, 32'hABCD_F00D);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h20, $urandom);
        check("word_0x20", rdata0, 32'hF00D8000);
        issue(0, 1'b0, 2'b00, 1'b0, 32'h21, $urandom);
        check("signed_byte", rdata0, 32'hFFFFFF80);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h21, $urandom);
        check("unsigned_byte", rdata0, 32'h00000080);
        issue(0, 1'b0, 2'b01, 1'b0, 32'h22, $urandom);
        check("signed_half", rdata0, 32'hFFFFF00D);

        issue(0, 1'b1, 2'b10, 1'b0, 32'h40, 32'h12345678);
        issue(0, 1'b1, 2'b01, 1'b0, 32'h41, 32'hFFFF_FFFF);
        check("misaligned_half_store", 32'(mis0), 32'd1);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h40, $urandom);
        check("word_0x40_unchanged", rdata0, 32'h12345678);
        issue(0, 1'b0, 2'b00, 1'b1, 32'h43, $urandom);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h42, $urandom);
        check("misaligned_word_load", 32'(mis0), 32'd1);
        check("misaligned_load_holds", rdata0, 32'h00000012);
        issue(0, 1'b1, 2'b11, 1'b0, 32'h40, 32'h0);
        check("illegal_size", 32'(mis0), 32'd1);

        issue(0, 1'b1, 2'b10, 1'b0, 32'(DEPTH*4), 32'hA5A5A5A5);
        check("wrap_testData", tdata0, 32'hA5A5A5A5);

        repeat (150) issue(0, 1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom);

        req[0] = 1'b1; we[0] = 1'b1; size[0] = 2'b10; uns[0] = 1'b0;
        addr[0] = 32'h08; wdata[0] = 32'h11111111;
        @(posedge clk); #1;
        req[0] = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("reset_mid_ready", 32'(ready0), 32'd0);
        check("reset_mid_testData", tdata0, 32'd0);
        q0.delete();
        q1.delete();
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        issue(0, 1'b0, 2'b10, 1'b0, 32'h08, $urandom);
        check("reset_mid_no_write", rdata0, 32'd0);

        issue(1, 1'b1, 2'b10, 1'b0, 32'h0C, 32'hCAFE_F00D);
        issue(1, 1'b0, 2'b10, 1'b0, 32'h0C, $urandom);
        check("fast_store_then_load", rdata1, 32'hCAFEF00D);
        repeat (60) issue(1, 1'($urandom), 2'($urandom), 1'($urandom), rand_addr(), $urandom);

        repeat (4) @(negedge clk);
        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
